// File: rtl/phase_scheduler.sv
// Two-approach intersection phase sequencer (NS main, EW side + EW protected left) with 1 s timebase.
// Latency: phase, countdown, sec_tick and pend flags are registered; transitions land one cycle after their condition.
// Backpressure: none; detector and preempt inputs are level-sampled every cycle and demand is latched until served.
module phase_scheduler #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int LEFT_TIME   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       req_left,
  input  logic       emerg,
  output logic [2:0] phase,
  output logic [3:0] countdown,
  output logic       sec_tick,
  output logic       ew_pend,
  output logic       left_pend
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_LEFT   = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6,
    EMERG     = 3'd7
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [3:0] MIN_G  = 4'(MIN_GREEN);
  localparam logic [3:0] MAX_G  = 4'(MAX_GREEN);
  localparam logic [3:0] YEL_T  = 4'(YELLOW_TIME);
  localparam logic [3:0] AR_T   = 4'(ALLRED_TIME);
  localparam logic [3:0] LEFT_T = 4'(LEFT_TIME);
  localparam logic [3:0] EMERG_CODE = 4'hE;
  localparam logic [3:0] ELAPSED_SAT = 4'd15;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [3:0]    elapsed;
  logic [3:0]    elapsed_nxt;
  logic          tick_nxt;
  logic          ew_pend_nxt;
  logic          left_pend_nxt;
  logic [3:0]    countdown_nxt;
  logic [3:0]    limit_nxt;
  logic          state_change;

  assign phase        = state;
  assign state_change = (state_nxt != state);

  // Per-phase time limit used for the displayed countdown.
  function automatic logic [3:0] limit_of(input state_t s);
    logic [3:0] lim;
    case (s)
      NS_GREEN, EW_GREEN:   lim = MAX_G;
      NS_YELLOW, EW_YELLOW: lim = YEL_T;
      ALLRED_A, ALLRED_B:   lim = AR_T;
      EW_LEFT:              lim = LEFT_T;
      default:              lim = MAX_G;
    endcase
    return lim;
  endfunction

  // Next-state selection: timed phase progression, emergency preempt overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      NS_GREEN: begin
        if ((ew_pend || left_pend) &&
            (((elapsed >= MIN_G) && !req_ns) || (elapsed >= MAX_G)))
          state_nxt = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (elapsed == YEL_T) state_nxt = ALLRED_A;
      end
      ALLRED_A: begin
        if (elapsed == AR_T) state_nxt = left_pend ? EW_LEFT : EW_GREEN;
      end
      EW_LEFT: begin
        if (elapsed == LEFT_T) state_nxt = EW_GREEN;
      end
      EW_GREEN: begin
        if (((elapsed >= MIN_G) && !req_ew) || (elapsed >= MAX_G))
          state_nxt = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (elapsed == YEL_T) state_nxt = ALLRED_B;
      end
      ALLRED_B: begin
        if (elapsed == AR_T) state_nxt = NS_GREEN;
      end
      EMERG: begin
        // Leaving preempt always goes through clearance before any green.
        if (!emerg) state_nxt = ALLRED_B;
      end
      default: state_nxt = NS_GREEN;
    endcase
    if (emerg) state_nxt = EMERG;
  end

  // Seconds timebase: prescaler wrap produces the tick; both restart on every phase change.
  always_comb begin
    presc_nxt   = presc;
    elapsed_nxt = elapsed;
    tick_nxt    = 1'b0;
    if (state_change) begin
      presc_nxt   = '0;
      elapsed_nxt = 4'd0;
    end else if (presc == PRESC_LAST) begin
      presc_nxt   = '0;
      tick_nxt    = 1'b1;
      elapsed_nxt = (elapsed == ELAPSED_SAT) ? ELAPSED_SAT : elapsed + 4'd1;
    end else begin
      presc_nxt = presc + PW'(1);
    end
  end

  // Demand latches: set by detectors, cleared when the served phase is entered (clear wins).
  always_comb begin
    ew_pend_nxt   = ew_pend | req_ew;
    left_pend_nxt = left_pend | req_left;
    if ((state_nxt == EW_GREEN) && (state != EW_GREEN)) ew_pend_nxt = 1'b0;
    if ((state_nxt == EW_LEFT) && (state != EW_LEFT))   left_pend_nxt = 1'b0;
  end

  // Countdown is derived from next phase/elapsed so it updates together with them.
  always_comb begin
    limit_nxt     = limit_of(state_nxt);
    countdown_nxt = 4'd0;
    if (state_nxt == EMERG)
      countdown_nxt = EMERG_CODE;
    else if (limit_nxt > elapsed_nxt)
      countdown_nxt = limit_nxt - elapsed_nxt;
  end

  // State and output registers with synchronous reset to resting NS green.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NS_GREEN;
      presc     <= '0;
      elapsed   <= 4'd0;
      sec_tick  <= 1'b0;
      countdown <= MAX_G;
      ew_pend   <= 1'b0;
      left_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      elapsed   <= elapsed_nxt;
      sec_tick  <= tick_nxt;
      countdown <= countdown_nxt;
      ew_pend   <= ew_pend_nxt;
      left_pend <= left_pend_nxt;
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: directed scenarios plus randomized traffic.
// Latency: a reference model advances once per clock edge; outputs sampled 1 time unit after the edge.
// Backpressure: not applicable; inputs are driven level-style from tasks.
module tb_phase_scheduler;

  localparam int TD   = 4;
  localparam int MIN  = 2;
  localparam int MAX  = 5;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int LEFT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_ns, req_ew, req_left, emerg;
  logic [2:0] phase;
  logic [3:0] countdown;
  logic       sec_tick, ew_pend, left_pend;

  int tests = 0;
  int fails = 0;

  phase_scheduler #(
    .TICK_DIV(TD), .MIN_GREEN(MIN), .MAX_GREEN(MAX),
    .YELLOW_TIME(YEL), .ALLRED_TIME(AR), .LEFT_TIME(LEFT)
  ) dut (
    .clk(clk), .reset(reset), .req_ns(req_ns), .req_ew(req_ew),
    .req_left(req_left), .emerg(emerg), .phase(phase),
    .countdown(countdown), .sec_tick(sec_tick),
    .ew_pend(ew_pend), .left_pend(left_pend)
  );

  always #5 clk = ~clk;

  // Reference model: phase, cycles spent in phase since entry, and demand flags.
  int m_ph   = 0;
  int m_cyc  = 0;
  bit m_ew   = 1'b0;
  bit m_left = 1'b0;

  // Observed phase runs (phase value, number of sampled cycles in it).
  int run_ph[$];
  int run_len[$];

  function automatic int m_el();
    return (m_cyc / TD > 15) ? 15 : m_cyc / TD;
  endfunction

  function automatic int lim(input int ph);
    case (ph)
      0, 4:    return MAX;
      1, 5:    return YEL;
      2, 6:    return AR;
      3:       return LEFT;
      default: return MAX;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit rns, input bit rew, input bit rleft, input bit rem);
    int el;
    int nx;
    if (rst) begin
      m_ph = 0; m_cyc = 0; m_ew = 1'b0; m_left = 1'b0;
      return;
    end
    el = m_el();
    nx = m_ph;
    case (m_ph)
      0: if ((m_ew || m_left) && ((el >= MIN && !rns) || el >= MAX)) nx = 1;
      1: if (el == YEL) nx = 2;
      2: if (el == AR) nx = m_left ? 3 : 4;
      3: if (el == LEFT) nx = 4;
      4: if ((el >= MIN && !rew) || el >= MAX) nx = 5;
      5: if (el == YEL) nx = 6;
      6: if (el == AR) nx = 0;
      default: if (!rem) nx = 6;
    endcase
    if (rem) nx = 7;
    m_ew   = (m_ew | rew) && !(nx == 4 && m_ph != 4);
    m_left = (m_left | rleft) && !(nx == 3 && m_ph != 3);
    m_cyc  = (nx != m_ph) ? 0 : m_cyc + 1;
    m_ph   = nx;
  endtask

  function automatic logic [9:0] mdl_vec();
    int el;
    int cd;
    el = m_el();
    cd = (m_ph == 7) ? 14 : ((lim(m_ph) > el) ? lim(m_ph) - el : 0);
    return {3'(m_ph), 4'(cd), 1'(m_cyc > 0 && (m_cyc % TD) == 0), 1'(m_ew), 1'(m_left)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {phase, countdown, sec_tick, ew_pend, left_pend};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(reset, req_ns, req_ew, req_left, emerg);
    #1;
    if (run_ph.size() > 0 && run_ph[run_ph.size()-1] == int'(phase))
      run_len[run_len.size()-1] += 1;
    else begin
      run_ph.push_back(int'(phase));
      run_len.push_back(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_ns = 1'b0; req_ew = 1'b0; req_left = 1'b0; emerg = 1'b0;
    run_ph.delete(); run_len.delete();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", phase); end
    tests++; if (countdown !== 4'(MAX)) begin fails++; $display("FAIL reset_countdown got %0d want %0d", countdown, MAX); end
    tests++; if (sec_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", sec_tick); end
    tests++; if (ew_pend !== 1'b0 || left_pend !== 1'b0) begin fails++; $display("FAIL reset_pend got %b%b want 00", ew_pend, left_pend); end
  endtask

  task automatic test_idle();
    int ticks = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (sec_tick === 1'b1) ticks++;
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL idle_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
      tests++; if (phase !== 3'd0) begin fails++; $display("FAIL idle_phase t=%0t got %0d want 0", $time, phase); end
    end
    tests++; if (ticks != 100 / TD) begin fails++; $display("FAIL idle_ticks got %0d want %0d", ticks, 100 / TD); end
    tests++; if (countdown !== 4'd0 || ew_pend !== 1'b0) begin fails++; $display("FAIL idle_end got cd=%0d ew=%b want cd=0 ew=0", countdown, ew_pend); end
  endtask

  task automatic test_ew_cycle();
    int exp_ph[7]  = '{0, 1, 2, 4, 5, 6, 0};
    int exp_len[7] = '{MIN*TD+1, YEL*TD+1, AR*TD+1, MIN*TD+1, YEL*TD+1, AR*TD+1, -1};
    logic [2:0] prev;
    do_reset();
    req_ew = 1'b1;
    cycle();
    req_ew = 1'b0;
    tests++; if (ew_pend !== 1'b1) begin fails++; $display("FAIL ew_latch got %b want 1", ew_pend); end
    for (int i = 0; i < 300 && run_ph.size() < 7; i++) begin
      prev = phase;
      cycle();
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL ew_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
      if (phase == 3'd4 && prev != 3'd4) begin
        tests++; if (ew_pend !== 1'b0) begin fails++; $display("FAIL ew_clear_on_entry got %b want 0", ew_pend); end
      end
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (i >= run_ph.size() || run_ph[i] != exp_ph[i] || (exp_len[i] >= 0 && run_len[i] != exp_len[i])) begin
        fails++;
        $display("FAIL ew_run%0d got ph=%0d len=%0d want ph=%0d len=%0d", i,
                 (i < run_ph.size()) ? run_ph[i] : -1, (i < run_len.size()) ? run_len[i] : -1, exp_ph[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_force_off();
    do_reset();
    req_ns = 1'b1; req_ew = 1'b1;
    cycle();
    req_ew = 1'b0;
    for (int i = 0; i < 100 && run_ph.size() < 2; i++) begin
      cycle();
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL forceoff_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    tests++;
    if (run_ph.size() < 2 || run_ph[1] != 1 || run_len[0] != MAX*TD+1) begin
      fails++;
      $display("FAIL forceoff_hold got runs=%0d len0=%0d want 2 runs len0=%0d", run_ph.size(), run_len[0], MAX*TD+1);
    end
    req_ns = 1'b0;
  endtask

  task automatic test_left();
    int exp_ph[8]  = '{0, 1, 2, 3, 4, 5, 6, 0};
    int exp_len[8] = '{MIN*TD+1, YEL*TD+1, AR*TD+1, LEFT*TD+1, MIN*TD+1, YEL*TD+1, AR*TD+1, -1};
    logic [2:0] prev;
    do_reset();
    req_ew = 1'b1; req_left = 1'b1;
    cycle();
    req_ew = 1'b0; req_left = 1'b0;
    for (int i = 0; i < 300 && run_ph.size() < 8; i++) begin
      prev = phase;
      cycle();
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL left_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
      if (phase == 3'd3 && prev != 3'd3) begin
        tests++; if (left_pend !== 1'b0) begin fails++; $display("FAIL left_clear_on_entry got %b want 0", left_pend); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= run_ph.size() || run_ph[i] != exp_ph[i] || (exp_len[i] >= 0 && run_len[i] != exp_len[i])) begin
        fails++;
        $display("FAIL left_run%0d got ph=%0d len=%0d want ph=%0d len=%0d", i,
                 (i < run_ph.size()) ? run_ph[i] : -1, (i < run_len.size()) ? run_len[i] : -1, exp_ph[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_emerg();
    int n6 = 1;
    do_reset();
    req_ew = 1'b1;
    cycle();
    req_ew = 1'b0;
    for (int i = 0; i < 60 && phase != 3'd1; i++) cycle();
    tests++; if (phase !== 3'd1) begin fails++; $display("FAIL emerg_reach_yellow got %0d want 1", phase); end
    cycle(); cycle();
    emerg = 1'b1;
    cycle();
    tests++; if (phase !== 3'd7 || countdown !== 4'hE) begin fails++; $display("FAIL emerg_enter got ph=%0d cd=%h want ph=7 cd=e", phase, countdown); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL emerg_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    emerg = 1'b0;
    cycle();
    tests++; if (phase !== 3'd6 || ew_pend !== 1'b1) begin fails++; $display("FAIL emerg_exit got ph=%0d ew=%b want ph=6 ew=1", phase, ew_pend); end
    for (int i = 0; i < 20 && phase == 3'd6; i++) begin
      cycle();
      if (phase == 3'd6) n6++;
    end
    tests++; if (n6 != AR*TD+1 || phase !== 3'd0) begin fails++; $display("FAIL emerg_clear got len=%0d ph=%0d want len=%0d ph=0", n6, phase, AR*TD+1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_ew = 1'b1; req_left = 1'b1;
    cycle();
    req_ew = 1'b0; req_left = 1'b0;
    for (int i = 0; i < 150 && phase != 3'd4; i++) cycle();
    tests++; if (phase !== 3'd4) begin fails++; $display("FAIL midreset_reach_ewgreen got %0d want 4", phase); end
    req_ew = 1'b1; req_left = 1'b1;
    cycle();
    reset = 1'b1; emerg = 1'b1;
    cycle();
    tests++;
    if (phase !== 3'd0 || ew_pend !== 1'b0 || left_pend !== 1'b0 || countdown !== 4'(MAX)) begin
      fails++;
      $display("FAIL midreset got ph=%0d ew=%b left=%b cd=%0d want ph=0 ew=0 left=0 cd=%0d", phase, ew_pend, left_pend, countdown, MAX);
    end
    reset = 1'b0; emerg = 1'b0; req_ew = 1'b0; req_left = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      req_ns   = ($urandom_range(0, 3) != 0);
      req_ew   = ($urandom_range(0, 24) == 0);
      req_left = ($urandom_range(0, 39) == 0);
      if (emerg) emerg = ($urandom_range(0, 7) != 0);
      else       emerg = ($urandom_range(0, 299) == 0);
      reset    = ($urandom_range(0, 1499) == 0);
      cycle();
      tests++; if (dut_vec() !== mdl_vec()) begin fails++; $display("FAIL random_lockstep t=%0t got %h want %h", $time, dut_vec(), mdl_vec()); end
    end
    reset = 1'b0; emerg = 1'b0; req_ns = 1'b0; req_ew = 1'b0; req_left = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_ns = 1'b0; req_ew = 1'b0; req_left = 1'b0; emerg = 1'b0;
    test_reset();
    test_idle();
    test_ew_cycle();
    test_force_off();
    test_left();
    test_emerg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
